// File: rtl/rom_stream_reader_if.sv
// Valid/ready word stream carrying ROM table data to a consumer; m_last marks a command's final word.
interface rom_stream_reader_if #(
  parameter int WIDTH = 8
) ();
  logic [WIDTH-1:0] m_data;
  logic             m_valid;
  logic             m_ready;
  logic             m_last;

  modport master (output m_data, output m_valid, output m_last, input m_ready);
  modport slave  (input m_data, input m_valid, input m_last, output m_ready);
endinterface

// File: rtl/rom_stream_reader.sv
// Sweeps a wrapping ROM address range and streams the words out; first word valid 3 edges after start.
// Reads are credit-limited so the 2-entry skid buffer never overflows under m_ready backpressure.
module rom_stream_reader #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int DEPTH_LOG = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [DEPTH_LOG-1:0] base_addr,
  input  logic [DEPTH_LOG:0]   count,
  output logic                 busy,
  output logic                 done,
  output logic [DEPTH_LOG-1:0] addr_rd,
  input  logic [WIDTH-1:0]     rom_data,
  rom_stream_reader_if.master  m
);
  localparam int AW = DEPTH_LOG;
  localparam int CW = DEPTH_LOG + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  issue_rem_q, issue_rem_d;
  logic [CW-1:0]  out_rem_q, out_rem_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic           inflight_q;
  logic [1:0]     occ_q, occ_d;
  logic [WIDTH-1:0] buf0_q, buf0_d, buf1_q, buf1_d;
  logic [2:0]     used;
  logic           pop, push, issue;

  assign pop   = m.m_valid & m.m_ready;
  assign push  = inflight_q;
  assign used  = 3'(occ_q) + 3'(inflight_q);
  // Credit: buffered plus in-flight words, net of this cycle's pop, must stay below two.
  assign issue = (state_q == S_RUN) && (issue_rem_q != '0) && (used < (3'd2 + 3'(pop)));

  always_comb begin
    state_d     = state_q;
    issue_rem_d = issue_rem_q;
    out_rem_d   = out_rem_q;
    addr_d      = addr_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (count != '0) begin
            state_d     = S_RUN;
            issue_rem_d = count;
            out_rem_d   = count;
            addr_d      = base_addr;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_RUN, S_DRAIN: begin
        if (issue) begin
          issue_rem_d = issue_rem_q - CW'(1);
          addr_d      = (addr_q == AW'(DEPTH - 1)) ? '0 : addr_q + AW'(1);
        end
        if (state_q == S_RUN && issue_rem_d == '0) state_d = S_DRAIN;
        if (pop) out_rem_d = out_rem_q - CW'(1);
        // Final handshake moves straight to DONE so done lands one cycle after m_last.
        if (out_rem_d == '0) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    occ_d  = occ_q;
    buf0_d = buf0_q;
    buf1_d = buf1_q;
    case ({push, pop})
      2'b10: begin
        if (occ_q == 2'd0) buf0_d = rom_data;
        else               buf1_d = rom_data;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        buf0_d = buf1_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          buf0_d = rom_data;
        end else begin
          buf0_d = buf1_q;
          buf1_d = rom_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      issue_rem_q <= '0;
      out_rem_q   <= '0;
      addr_q      <= '0;
      inflight_q  <= 1'b0;
      occ_q       <= 2'd0;
      buf0_q      <= '0;
      buf1_q      <= '0;
    end else begin
      state_q     <= state_d;
      issue_rem_q <= issue_rem_d;
      out_rem_q   <= out_rem_d;
      addr_q      <= addr_d;
      inflight_q  <= issue;
      occ_q       <= occ_d;
      buf0_q      <= buf0_d;
      buf1_q      <= buf1_d;
    end
  end

  assign busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done      = (state_q == S_DONE);
  assign addr_rd   = addr_q;
  assign m.m_data  = buf0_q;
  assign m.m_valid = (occ_q != 2'd0);
  assign m.m_last  = m.m_valid && (out_rem_q == CW'(1));
endmodule

// File: tb/tb_rom_stream_reader.sv
// Bench: ROM model rom[i]=A0+i, scoreboard of expected words per command, negedge monitor.
module tb_rom_stream_reader;
  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int DL    = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [DL-1:0] base_addr = '0;
  logic [DL:0]   count = '0;
  logic          busy, done;
  logic [DL-1:0] addr_rd;
  logic [WIDTH-1:0] rom_data = '0;

  rom_stream_reader_if #(.WIDTH(WIDTH)) sif ();

  rom_stream_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .count(count),
    .busy(busy), .done(done), .addr_rd(addr_rd), .rom_data(rom_data), .m(sif)
  );

  always #5 clk = ~clk;

  // Synchronous ROM, one-cycle registered read.
  always @(posedge clk) rom_data <= 8'(8'hA0 + addr_rd);

  typedef struct packed { logic [7:0] d; logic l; } exp_t;
  exp_t exp_q[$];

  int total = 0;
  int bad = 0;
  int hs_cnt = 0;
  bit done_due = 0;
  bit zero_due = 0;
  bit prev_stall = 0;
  logic [7:0] prev_d = '0;
  logic prev_l = 1'b0;
  int rdy_mode = 0;
  int pat_i = 0;
  logic [7:0] pat = 8'hE9;   // ready sequence 1,0,0,1,0,1,1,1 from bit 0 upward

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 0;
      done_due   = 0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", 32'(sif.m_valid), 1);
        chk("stall_data", 32'(sif.m_data), 32'(prev_d));
        chk("stall_last", 32'(sif.m_last), 32'(prev_l));
      end
      if (done_due || zero_due || done) begin
        chk("done", 32'(done), 32'(done_due || zero_due));
        if (done) chk("busy_at_done", 32'(busy), 0);
      end
      zero_due = 0;
      done_due = 0;
      if (sif.m_valid && sif.m_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_word: got %0h want none", sif.m_data);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("data", 32'(sif.m_data), 32'(e.d));
          chk("last", 32'(sif.m_last), 32'(e.l));
          done_due = e.l;
        end
      end
      prev_stall = sif.m_valid && !sif.m_ready;
      prev_d     = sif.m_data;
      prev_l     = sif.m_last;
    end
  end

  task automatic set_ready();
    case (rdy_mode)
      1: sif.m_ready = 1'($urandom_range(0, 1));
      2: begin
        if (sif.m_valid) begin
          sif.m_ready = (pat_i < 8) ? pat[pat_i] : 1'b1;
          pat_i++;
        end else begin
          sif.m_ready = 1'b1;
        end
      end
      default: sif.m_ready = 1'b1;
    endcase
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    set_ready();
  endtask

  task automatic push_expect(input int b, input int c);
    for (int k = 0; k < c; k++) begin
      exp_t e;
      e.d = 8'(8'hA0 + ((b + k) % DEPTH));
      e.l = (k == c - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_done();
    bit got = 0;
    for (int i = 0; i < 300 && !got; i++) begin
      if (done) got = 1;
      else step();
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got no done want done within 300 cycles");
    end
    step();
    chk("queue_empty", 32'(exp_q.size()), 0);
    chk("busy_idle", 32'(busy), 0);
  endtask

  task automatic run_cmd(input int b, input int c, input int mode, input bit lat, input bit inject);
    logic [31:0] a_exp;
    a_exp = (c != 0) ? 32'(b) : 32'(addr_rd);
    rdy_mode = mode;
    pat_i = 0;
    push_expect(b, c);
    start = 1'b1;
    base_addr = DL'(b);
    count = (DL+1)'(c);
    step();
    start = 1'b0;
    if (c == 0) zero_due = 1;
    chk("busy_after_start", 32'(busy), 32'(c != 0));
    chk("addr_after_start", 32'(addr_rd), a_exp);
    if (lat) begin
      @(negedge clk); chk("lat_valid_e0", 32'(sif.m_valid), 0);
      @(negedge clk); chk("lat_valid_e1", 32'(sif.m_valid), 0);
      @(negedge clk); chk("lat_valid_e2", 32'(sif.m_valid), 1);
    end
    if (inject) begin
      step();
      step();
      start = 1'b1;
      base_addr = DL'(9);
      count = (DL+1)'(3);
      step();
      start = 1'b0;
    end
    wait_done();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin
    logic [DL-1:0] a_hold;
    int h0;
    sif.m_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_addr", 32'(addr_rd), 0);
    chk("rst_valid", 32'(sif.m_valid), 0);
    chk("rst_last", 32'(sif.m_last), 0);
    chk("rst_data", 32'(sif.m_data), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step();

    run_cmd(0, 4, 0, 1, 0);
    run_cmd(14, 4, 0, 0, 0);
    run_cmd(3, 6, 2, 0, 0);

    a_hold = addr_rd;
    run_cmd(9, 0, 0, 0, 0);
    chk("zero_addr_hold", 32'(addr_rd), 32'(a_hold));
    chk("zero_no_valid", 32'(sif.m_valid), 0);

    run_cmd(0, 5, 0, 0, 1);
    run_cmd(10, 20, 1, 0, 0);

    // Abort a command after two transfers.
    rdy_mode = 0;
    push_expect(0, 8);
    start = 1'b1;
    base_addr = '0;
    count = (DL+1)'(8);
    h0 = hs_cnt;
    step();
    start = 1'b0;
    for (int i = 0; i < 50 && (hs_cnt - h0) < 2; i++) step();
    chk("abort_words_seen", 32'(hs_cnt - h0), 2);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_addr", 32'(addr_rd), 0);
    chk("abort_valid", 32'(sif.m_valid), 0);
    chk("abort_last", 32'(sif.m_last), 0);
    chk("abort_data", 32'(sif.m_data), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step();
    run_cmd(5, 2, 0, 0, 0);

    for (int n = 0; n < 12; n++) begin
      run_cmd(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 2 * DEPTH - 1)), 1, 0, 0);
    end

    repeat (3) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
